// File: rtl/apb_pkg.sv
// Shared APB widths, FSM state type and the address-legality rule for apb_slave_mem.
package apb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int IDX_W  = ADDR_W - 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_t;

   // A byte address is legal only when word aligned and inside the populated words.
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int depth);
      return (addr[1:0] != 2'b00) || (int'(addr[ADDR_W-1:2]) >= depth);
   endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 32-bit register file: byte-strobed synchronous write, asynchronous read, async clear.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [STRB_W-1:0] wstrb_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_in_range;
   logic              rd_in_range;

   assign wr_in_range = {1'b0, waddr_i} < DEPTH_L;
   assign rd_in_range = {1'b0, raddr_i} < DEPTH_L;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && wr_in_range) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_i[b]) begin
               mem_q[waddr_i[AW-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = rd_in_range ? mem_q[raddr_i[AW-1:0]] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer memory: IDLE/ACCESS FSM, optional wait counter (APB_SLV_WAIT_EN), address error decode.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic [STRB_W-1:0] pstrb,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              dbg_state_o
);

   // Handshake: a transfer is accepted by a setup cycle (psel=1, penable=0) in IDLE and
   // completes at the first edge with psel & penable & pready; psel low in ACCESS aborts it.

   apb_state_t        state_q;
   logic              err_q;
   logic [DATA_W-1:0] prdata_q;
   logic [DATA_W-1:0] rd_word;
   logic              setup;
   logic              setup_err;
   logic              complete;
   logic              cnt_zero;
   logic              we;

   assign setup     = psel & ~penable;
   assign setup_err = addr_err(paddr, DEPTH);
   assign complete  = (state_q == ACCESS) & psel & penable & pready;
   assign we        = complete & pwrite & ~err_q;

`ifdef APB_SLV_WAIT_EN
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && setup) begin
         cnt_d = CNT_INIT;
      end else if (state_q == ACCESS && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_zero = (cnt_q == '0);
`else
   assign cnt_zero = 1'b1;
`endif

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state_q  <= IDLE;
         err_q    <= 1'b0;
         prdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (setup) begin
                  state_q <= ACCESS;
                  err_q   <= setup_err;
                  // Read data is captured once at setup; writes and errors leave it alone.
                  if (!pwrite && !setup_err) begin
                     prdata_q <= rd_word;
                  end
               end
            end
            ACCESS: begin
               if (!psel || complete) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pready      = (state_q == ACCESS) & cnt_zero;
   assign pslverr     = pready & err_q;
   assign prdata      = prdata_q;
   assign dbg_state_o = state_q;

   apb_slave_regfile #(
      .DEPTH(DEPTH)
   ) u_regfile (
      .clk_i  (pclk),
      .rst_ni (preset),
      .we_i   (we),
      .waddr_i(paddr[ADDR_W-1:2]),
      .wdata_i(pwdata),
      .wstrb_i(pstrb),
      .raddr_i(paddr[ADDR_W-1:2]),
      .rdata_o(rd_word)
   );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem against a word-array reference model.
module tb_apb_slave_mem;

   localparam int DEPTH       = 32;
   localparam int WAIT_CYCLES = 2;
   localparam int TIMEOUT     = 64;
`ifdef APB_SLV_WAIT_EN
   localparam int N_WAIT = WAIT_CYCLES;
`else
   localparam int N_WAIT = 0;
`endif
   localparam int EXP_LAT = 1 + N_WAIT;

   logic        pclk    = 1'b0;
   logic        preset  = 1'b0;
   logic        psel    = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite  = 1'b0;
   logic [7:0]  paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic [3:0]  pstrb   = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        dbg_state;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_model [DEPTH];
   logic [31:0] prdata_model;
   logic [31:0] exp_q [$];

   // ---------------- clock / DUT ----------------
   always #5 pclk = ~pclk;

   apb_slave_mem #(
      .DEPTH      (DEPTH),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .pclk       (pclk),
      .preset     (preset),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .pstrb      (pstrb),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr),
      .dbg_state_o(dbg_state)
   );

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
      prdata_model = 32'h0;
   endtask

   task automatic model_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                             input logic [3:0] st, output logic exp_err);
      int word;
      word    = int'(addr) / 4;
      exp_err = (int'(addr) % 4 != 0) || (word >= DEPTH);
      if (!exp_err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (st[b]) mem_model[word][8*b +: 8] = wd[8*b +: 8];
         end else begin
            prdata_model = mem_model[word];
         end
      end
   endtask

   // ---------------- driver ----------------
   // Starts in a fresh cycle (1 time unit after an edge) and returns in one, so calls chain back-to-back.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, output logic [31:0] rd, output logic err_seen,
                           output int lat, output logic early_err, output logic timed_out);
      paddr     = addr;
      pwrite    = wr;
      pwdata    = wd;
      pstrb     = st;
      psel      = 1'b1;
      penable   = 1'b0;
      early_err = 1'b0;
      timed_out = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      lat     = 1;
      while (1) begin
         @(negedge pclk);
         if (pready) break;
         if (pslverr) early_err = 1'b1;
         if (lat >= TIMEOUT) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge pclk); #1;
         lat++;
      end
      err_seen = pslverr;
      @(posedge pclk); #1;
      rd      = prdata;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge pclk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] rd;
      logic        err, early, tmo, exp_err;
      int          lat;
      preset = 1'b0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h expected %h", prdata, 32'h0); end
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b expected 0", pready); end
      checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b expected 0", pslverr); end
      checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
      @(posedge pclk); #1;
      preset = 1'b1;
      model_reset();
      idle_cycle();
      model_xfer(1'b0, 8'h00, 32'h0, 4'h0, exp_err);
      apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, lat, early, tmo);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_read0: got %h expected %h", rd, 32'h0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_read0_err: got %b expected 0", err); end
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL reset_read0_latency: got %0d expected %0d", lat, EXP_LAT); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_read0_timeout: pready never rose"); end
   endtask

   task automatic test_strobe();
      logic [31:0] rd;
      logic        err, early, tmo, exp_err;
      int          lat;
      model_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'b0101, exp_err);
      apb_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'b0101, rd, err, lat, early, tmo);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL strobe_write_err: got %b expected 0", err); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL strobe_write_prdata_hold: got %h expected %h", rd, 32'h0); end
      idle_cycle();
      model_xfer(1'b0, 8'h10, 32'h0, 4'hF, exp_err);
      apb_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, err, lat, early, tmo);
      checks++; if (rd !== 32'h00AD00EF) begin errors++; $display("FAIL strobe_read: got %h expected %h", rd, 32'h00AD00EF); end
      checks++; if (rd !== prdata_model) begin errors++; $display("FAIL strobe_read_model: got %h expected %h", rd, prdata_model); end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        err, early, tmo, exp_err;
      int          lat;
      logic [7:0]  bad_addr [2];
      bad_addr[0] = 8'h81;
      bad_addr[1] = 8'h80;
      model_xfer(1'b0, 8'h00, 32'h0, 4'h0, exp_err);
      apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, lat, early, tmo);
      for (int i = 0; i < 2; i++) begin
         model_xfer(1'b0, bad_addr[i], 32'h0, 4'h0, exp_err);
         apb_xfer(1'b0, bad_addr[i], 32'h0, 4'h0, rd, err, lat, early, tmo);
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_read_%h: pslverr got %b expected 1", bad_addr[i], err); end
         checks++; if (early !== 1'b0) begin errors++; $display("FAIL err_early_%h: pslverr got 1 before pready expected 0", bad_addr[i]); end
         checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_prdata_%h: got %h expected %h", bad_addr[i], rd, 32'h0); end
         checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL err_latency_%h: got %0d expected %0d", bad_addr[i], lat, EXP_LAT); end
      end
      // Misaligned and out-of-range writes must not touch any word.
      model_xfer(1'b1, 8'h11, 32'hFFFFFFFF, 4'hF, exp_err);
      apb_xfer(1'b1, 8'h11, 32'hFFFFFFFF, 4'hF, rd, err, lat, early, tmo);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_write_11: pslverr got %b expected 1", err); end
      model_xfer(1'b1, 8'h84, 32'hFFFFFFFF, 4'hF, exp_err);
      apb_xfer(1'b1, 8'h84, 32'hFFFFFFFF, 4'hF, rd, err, lat, early, tmo);
      model_xfer(1'b0, 8'h10, 32'h0, 4'h0, exp_err);
      apb_xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, err, lat, early, tmo);
      checks++; if (rd !== 32'h00AD00EF) begin errors++; $display("FAIL err_mem_unchanged: got %h expected %h", rd, 32'h00AD00EF); end
      model_xfer(1'b0, 8'h00, 32'h0, 4'h0, exp_err);
      apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, lat, early, tmo);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_word0_unchanged: got %h expected %h", rd, 32'h0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        err, early, tmo, exp_err;
      int          lat_w, lat_r;
      model_xfer(1'b1, 8'h04, 32'h12345678, 4'hF, exp_err);
      apb_xfer(1'b1, 8'h04, 32'h12345678, 4'hF, rd, err, lat_w, early, tmo);
      model_xfer(1'b0, 8'h04, 32'h0, 4'h0, exp_err);
      apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, lat_r, early, tmo);
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL b2b_read: got %h expected %h", rd, 32'h12345678); end
      checks++; if (lat_w !== EXP_LAT) begin errors++; $display("FAIL b2b_write_latency: got %0d expected %0d", lat_w, EXP_LAT); end
      checks++; if (lat_r !== EXP_LAT) begin errors++; $display("FAIL b2b_read_latency: got %0d expected %0d", lat_r, EXP_LAT); end
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      logic        err, early, tmo, exp_err;
      int          lat;
      // psel dropped during ACCESS
      paddr = 8'h08; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL abort_in_access: state got %b expected 1", dbg_state); end
      psel = 1'b0;
      @(posedge pclk); #1;
      checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL abort_back_idle: state got %b expected 0", dbg_state); end
      model_xfer(1'b0, 8'h08, 32'h0, 4'h0, exp_err);
      apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, lat, early, tmo);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_psel_read08: got %h expected %h", rd, 32'h0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_psel_err: got %b expected 0", err); end
      // reset asserted mid-ACCESS, with other memory already holding data
      model_xfer(1'b1, 8'h0C, 32'h5A5A5A5A, 4'hF, exp_err);
      apb_xfer(1'b1, 8'h0C, 32'h5A5A5A5A, 4'hF, rd, err, lat, early, tmo);
      model_xfer(1'b0, 8'h0C, 32'h0, 4'h0, exp_err);
      apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, lat, early, tmo);
      paddr = 8'h08; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      #2 preset = 1'b0;
      #1;
      checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got %b expected 0", dbg_state); end
      checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL rst_mid_prdata: got %h expected %h", prdata, 32'h0); end
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rst_mid_pready: got %b expected 0", pready); end
      checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_mid_pslverr: got %b expected 0", pslverr); end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      preset = 1'b1;
      model_reset();
      idle_cycle();
      apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, lat, early, tmo);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_read08: got %h expected %h", rd, 32'h0); end
      apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, lat, early, tmo);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_read0c: got %h expected %h", rd, 32'h0); end
   endtask

   task automatic test_random();
      logic [31:0] rd, exp_rd, wd;
      logic [7:0]  addr;
      logic [3:0]  st;
      logic        wr, err, early, tmo, exp_err;
      int          lat;
      for (int n = 0; n < 300; n++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8) addr = 8'($urandom_range(0, DEPTH - 1) * 4);
         else                          addr = 8'($urandom_range(0, 255));
         wd = $urandom;
         st = 4'($urandom_range(0, 15));
         model_xfer(wr, addr, wd, st, exp_err);
         exp_q.push_back(prdata_model);
         apb_xfer(wr, addr, wd, st, rd, err, lat, early, tmo);
         exp_rd = exp_q.pop_front();
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_prdata[%0d] wr=%b addr=%h: got %h expected %h", n, wr, addr, rd, exp_rd); end
         checks++; if (err !== exp_err) begin errors++; $display("FAIL rand_pslverr[%0d] addr=%h: got %b expected %b", n, addr, err, exp_err); end
         checks++; if (lat !== EXP_LAT || early !== 1'b0) begin errors++; $display("FAIL rand_timing[%0d]: latency %0d early_err %b expected %0d and 0", n, lat, early, EXP_LAT); end
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      for (int i = 0; i < DEPTH; i++) begin
         model_xfer(1'b0, 8'(i * 4), 32'h0, 4'h0, exp_err);
         exp_q.push_back(prdata_model);
         apb_xfer(1'b0, 8'(i * 4), 32'h0, 4'h0, rd, err, lat, early, tmo);
         exp_rd = exp_q.pop_front();
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL sweep_word[%0d]: got %h expected %h", i, rd, exp_rd); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      model_reset();
      test_reset();
      test_strobe();
      test_errors();
      test_back_to_back();
      test_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
